// File: rtl/multiexp_g2_kernel_multi_counter_if.sv
// ---------------------------------------------------------------------------
// multiexp_g2_kernel_multi_counter_if
// Purpose : Bundles the control strobes, per-channel data and the status
//           outputs of the multi-channel counter bank into one interface.
// Signals : clken                  global enable
//           load/incr/decr         per-channel strobes
//           step, load_value       per-channel packed data
//           clr_flags              per-channel sticky clear
//           count, is_zero, is_max registered count and level flags
//           ovf/udf_pulse/sticky   event pulses and latched events
// Modports: master drives controls and observes status; slave is the counter.
// ---------------------------------------------------------------------------
interface multiexp_g2_kernel_multi_counter_if #(
  parameter int C_NUM_CH     = 4,
  parameter int C_WIDTH      = 8,
  parameter int C_STEP_WIDTH = 4
) ();
  logic                             clken;
  logic [C_NUM_CH-1:0]              load;
  logic [C_NUM_CH-1:0]              incr;
  logic [C_NUM_CH-1:0]              decr;
  logic [C_NUM_CH*C_STEP_WIDTH-1:0] step;
  logic [C_NUM_CH*C_WIDTH-1:0]      load_value;
  logic [C_NUM_CH-1:0]              clr_flags;
  logic [C_NUM_CH*C_WIDTH-1:0]      count;
  logic [C_NUM_CH-1:0]              is_zero;
  logic [C_NUM_CH-1:0]              is_max;
  logic [C_NUM_CH-1:0]              ovf_pulse;
  logic [C_NUM_CH-1:0]              udf_pulse;
  logic [C_NUM_CH-1:0]              ovf_sticky;
  logic [C_NUM_CH-1:0]              udf_sticky;

  modport master (
    output clken, load, incr, decr, step, load_value, clr_flags,
    input  count, is_zero, is_max, ovf_pulse, udf_pulse, ovf_sticky, udf_sticky
  );

  modport slave (
    input  clken, load, incr, decr, step, load_value, clr_flags,
    output count, is_zero, is_max, ovf_pulse, udf_pulse, ovf_sticky, udf_sticky
  );
endinterface

// File: rtl/multiexp_g2_kernel_multi_counter.sv
// ---------------------------------------------------------------------------
// multiexp_g2_kernel_multi_counter
// Purpose : Bank of C_NUM_CH independent up/down counters with programmable
//           step, saturate or wrap on overflow/underflow, registered level
//           flags and overflow/underflow pulse + sticky flags.
// Ports   : clk  - sole clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - slave side of multiexp_g2_kernel_multi_counter_if
// Priority per channel on an enabled edge: load > (incr xor decr) > hold.
// ---------------------------------------------------------------------------
module multiexp_g2_kernel_multi_counter #(
  parameter int                 C_NUM_CH     = 4,
  parameter int                 C_WIDTH      = 8,
  parameter int                 C_STEP_WIDTH = 4,
  parameter int                 C_SATURATE   = 1,
  parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
  input logic                                  clk,
  input logic                                  rst,
  multiexp_g2_kernel_multi_counter_if.slave    bus
);

  localparam logic [C_WIDTH-1:0] C_MAX       = '1;
  localparam logic               C_INIT_ZERO = (C_INIT == '0);
  localparam logic               C_INIT_MAX  = (C_INIT == C_MAX);

  for (genvar ch = 0; ch < C_NUM_CH; ch++) begin : g_ch
    logic [C_WIDTH-1:0] r_count;
    logic               r_is_zero;
    logic               r_is_max;
    logic               r_ovf_pulse;
    logic               r_udf_pulse;
    logic               r_ovf_sticky;
    logic               r_udf_sticky;

    logic [C_WIDTH:0]   w_step;
    logic [C_WIDTH:0]   w_sum;
    logic [C_WIDTH:0]   w_diff;
    logic [C_WIDTH-1:0] w_nxt;
    logic               w_ovf;
    logic               w_udf;

    assign w_step = {{(C_WIDTH+1-C_STEP_WIDTH){1'b0}},
                     bus.step[ch*C_STEP_WIDTH +: C_STEP_WIDTH]};
    // One extra bit: carry of the sum marks overflow, borrow of the
    // difference marks step > count (underflow).
    assign w_sum  = {1'b0, r_count} + w_step;
    assign w_diff = {1'b0, r_count} - w_step;

    always_comb begin
      w_nxt = r_count;
      w_ovf = 1'b0;
      w_udf = 1'b0;
      if (bus.load[ch]) begin
        w_nxt = bus.load_value[ch*C_WIDTH +: C_WIDTH];
      end else if (bus.incr[ch] && !bus.decr[ch]) begin
        if (w_sum[C_WIDTH]) begin
          w_ovf = 1'b1;
          w_nxt = (C_SATURATE != 0) ? C_MAX : w_sum[C_WIDTH-1:0];
        end else begin
          w_nxt = w_sum[C_WIDTH-1:0];
        end
      end else if (bus.decr[ch] && !bus.incr[ch]) begin
        if (w_diff[C_WIDTH]) begin
          w_udf = 1'b1;
          w_nxt = (C_SATURATE != 0) ? '0 : w_diff[C_WIDTH-1:0];
        end else begin
          w_nxt = w_diff[C_WIDTH-1:0];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_count      <= C_INIT;
        r_is_zero    <= C_INIT_ZERO;
        r_is_max     <= C_INIT_MAX;
        r_ovf_pulse  <= 1'b0;
        r_udf_pulse  <= 1'b0;
        r_ovf_sticky <= 1'b0;
        r_udf_sticky <= 1'b0;
      end else begin
        // Pulses are cleared on disabled edges so they never stretch.
        r_ovf_pulse <= bus.clken & w_ovf;
        r_udf_pulse <= bus.clken & w_udf;
        if (bus.clken) begin
          r_count      <= w_nxt;
          r_is_zero    <= (w_nxt == '0);
          r_is_max     <= (w_nxt == C_MAX);
          // A new event beats a simultaneous clear.
          r_ovf_sticky <= w_ovf | (r_ovf_sticky & ~bus.clr_flags[ch]);
          r_udf_sticky <= w_udf | (r_udf_sticky & ~bus.clr_flags[ch]);
        end
      end
    end

    assign bus.count[ch*C_WIDTH +: C_WIDTH] = r_count;
    assign bus.is_zero[ch]    = r_is_zero;
    assign bus.is_max[ch]     = r_is_max;
    assign bus.ovf_pulse[ch]  = r_ovf_pulse;
    assign bus.udf_pulse[ch]  = r_udf_pulse;
    assign bus.ovf_sticky[ch] = r_ovf_sticky;
    assign bus.udf_sticky[ch] = r_udf_sticky;
  end

endmodule

// File: tb/tb_multiexp_g2_kernel_multi_counter.sv
// ---------------------------------------------------------------------------
// tb_multiexp_g2_kernel_multi_counter
// Drives one saturating and one wrapping instance with identical stimulus
// and compares both against an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_multiexp_g2_kernel_multi_counter;
  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int SW  = 4;
  localparam int MAXV = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              clken;
  logic [NCH-1:0]    load, incr, decr, clr_flags;
  logic [NCH*SW-1:0] step;
  logic [NCH*W-1:0]  load_value;

  multiexp_g2_kernel_multi_counter_if #(.C_NUM_CH(NCH), .C_WIDTH(W), .C_STEP_WIDTH(SW)) bus_s ();
  multiexp_g2_kernel_multi_counter_if #(.C_NUM_CH(NCH), .C_WIDTH(W), .C_STEP_WIDTH(SW)) bus_w ();

  assign bus_s.clken = clken;      assign bus_w.clken = clken;
  assign bus_s.load = load;        assign bus_w.load = load;
  assign bus_s.incr = incr;        assign bus_w.incr = incr;
  assign bus_s.decr = decr;        assign bus_w.decr = decr;
  assign bus_s.step = step;        assign bus_w.step = step;
  assign bus_s.load_value = load_value; assign bus_w.load_value = load_value;
  assign bus_s.clr_flags = clr_flags;   assign bus_w.clr_flags = clr_flags;

  multiexp_g2_kernel_multi_counter #(
    .C_NUM_CH(NCH), .C_WIDTH(W), .C_STEP_WIDTH(SW), .C_SATURATE(1), .C_INIT(8'd0)
  ) u_sat (.clk(clk), .rst(rst), .bus(bus_s));

  multiexp_g2_kernel_multi_counter #(
    .C_NUM_CH(NCH), .C_WIDTH(W), .C_STEP_WIDTH(SW), .C_SATURATE(0), .C_INIT(8'd0)
  ) u_wrap (.clk(clk), .rst(rst), .bus(bus_w));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: index 0 = saturating instance, 1 = wrapping instance.
  int m_cnt [2][NCH];
  bit m_op  [2][NCH];
  bit m_up  [2][NCH];
  bit m_os  [2][NCH];
  bit m_us  [2][NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < NCH; c++) begin
        m_cnt[m][c] = 0;
        m_op[m][c] = 0; m_up[m][c] = 0; m_os[m][c] = 0; m_us[m][c] = 0;
      end
  endtask

  task automatic model_edge();
    int cur, st, nxt;
    bit ov, ud;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < NCH; c++) begin
        if (!clken) begin
          m_op[m][c] = 0;
          m_up[m][c] = 0;
        end else begin
          cur = m_cnt[m][c];
          st  = int'(step[c*SW +: SW]);
          nxt = cur; ov = 0; ud = 0;
          if (load[c]) begin
            nxt = int'(load_value[c*W +: W]);
          end else if (incr[c] && !decr[c]) begin
            nxt = cur + st;
            if (nxt > MAXV) begin
              ov = 1;
              nxt = (m == 0) ? MAXV : nxt - (MAXV + 1);
            end
          end else if (decr[c] && !incr[c]) begin
            nxt = cur - st;
            if (nxt < 0) begin
              ud = 1;
              nxt = (m == 0) ? 0 : nxt + (MAXV + 1);
            end
          end
          m_cnt[m][c] = nxt;
          m_op[m][c] = ov;
          m_up[m][c] = ud;
          m_os[m][c] = ov | (m_os[m][c] & !clr_flags[c]);
          m_us[m][c] = ud | (m_us[m][c] & !clr_flags[c]);
        end
      end
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] e_cnt, e_z, e_mx, e_op, e_up, e_os, e_us;
    logic [31:0] o_cnt, o_z, o_mx, o_op, o_up, o_os, o_us;
    for (int m = 0; m < 2; m++) begin
      e_cnt = '0; e_z = '0; e_mx = '0; e_op = '0; e_up = '0; e_os = '0; e_us = '0;
      for (int c = 0; c < NCH; c++) begin
        e_cnt[c*W +: W] = m_cnt[m][c][W-1:0];
        e_z[c]  = (m_cnt[m][c] == 0);
        e_mx[c] = (m_cnt[m][c] == MAXV);
        e_op[c] = m_op[m][c];
        e_up[c] = m_up[m][c];
        e_os[c] = m_os[m][c];
        e_us[c] = m_us[m][c];
      end
      if (m == 0) begin
        o_cnt = bus_s.count; o_z = 32'(bus_s.is_zero); o_mx = 32'(bus_s.is_max);
        o_op = 32'(bus_s.ovf_pulse); o_up = 32'(bus_s.udf_pulse);
        o_os = 32'(bus_s.ovf_sticky); o_us = 32'(bus_s.udf_sticky);
      end else begin
        o_cnt = bus_w.count; o_z = 32'(bus_w.is_zero); o_mx = 32'(bus_w.is_max);
        o_op = 32'(bus_w.ovf_pulse); o_up = 32'(bus_w.udf_pulse);
        o_os = 32'(bus_w.ovf_sticky); o_us = 32'(bus_w.udf_sticky);
      end
      check($sformatf("%s_m%0d_count", tag, m), o_cnt, e_cnt);
      check($sformatf("%s_m%0d_is_zero", tag, m), o_z, e_z);
      check($sformatf("%s_m%0d_is_max", tag, m), o_mx, e_mx);
      check($sformatf("%s_m%0d_ovf_pulse", tag, m), o_op, e_op);
      check($sformatf("%s_m%0d_udf_pulse", tag, m), o_up, e_up);
      check($sformatf("%s_m%0d_ovf_sticky", tag, m), o_os, e_os);
      check($sformatf("%s_m%0d_udf_sticky", tag, m), o_us, e_us);
    end
  endtask

  task automatic idle();
    clken = 1'b1; load = '0; incr = '0; decr = '0; clr_flags = '0;
    step = '0; load_value = '0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    idle();
    model_reset();
    #2 rst = 1'b1;
    #1 compare_all("reset_init");
    @(posedge clk); #1 compare_all("reset_hold");
    rst = 1'b0;

    // Load ch0=250, ch1=3, ch2=100, ch3=255.
    load = 4'b1111;
    load_value = {8'd255, 8'd100, 8'd3, 8'd250};
    tick("load");

    // ch0 incr 10 (sat: 255 ovf), ch1 decr 5 (wrap: 254 udf).
    idle();
    incr[0] = 1'b1; step[0 +: SW] = 4'd10;
    decr[1] = 1'b1; step[SW +: SW] = 4'd5;
    tick("ovf_udf");
    check("sat_ch0_cnt_255", 32'(bus_s.count[7:0]), 32'd255);
    check("sat_ch0_ovf_pulse", 32'(bus_s.ovf_pulse[0]), 32'd1);
    check("sat_ch0_is_max", 32'(bus_s.is_max[0]), 32'd1);
    check("wrap_ch1_cnt_254", 32'(bus_w.count[15:8]), 32'd254);
    check("wrap_ch1_udf_pulse", 32'(bus_w.udf_pulse[1]), 32'd1);

    // ch0 decr 15, ch1 incr 2.
    idle();
    decr[0] = 1'b1; step[0 +: SW] = 4'd15;
    incr[1] = 1'b1; step[SW +: SW] = 4'd2;
    tick("recover");
    check("sat_ch0_cnt_240", 32'(bus_s.count[7:0]), 32'd240);
    check("sat_ch0_pulse_gone", 32'(bus_s.ovf_pulse[0]), 32'd0);
    check("sat_ch0_sticky_kept", 32'(bus_s.ovf_sticky[0]), 32'd1);
    check("wrap_ch1_cnt_0", 32'(bus_w.count[15:8]), 32'd0);
    check("wrap_ch1_ovf_pulse", 32'(bus_w.ovf_pulse[1]), 32'd1);
    check("wrap_ch1_is_zero", 32'(bus_w.is_zero[1]), 32'd1);

    // MAX plus one on ch3 (already 255).
    idle();
    incr[3] = 1'b1; step[3*SW +: SW] = 4'd1;
    tick("max_plus_one");

    // Priority: load beats incr.
    idle();
    load[0] = 1'b1; incr[0] = 1'b1; step[0 +: SW] = 4'd15;
    load_value[0 +: W] = 8'd7;
    tick("load_prio");
    check("load_prio_cnt_7", 32'(bus_s.count[7:0]), 32'd7);
    idle();
    incr[0] = 1'b1; decr[0] = 1'b1; step[0 +: SW] = 4'd3;
    tick("incr_decr_hold");
    idle();
    incr = 4'b1111;
    tick("step0_hold");

    // Sticky clear alone, then clear racing a new underflow on ch1.
    idle();
    clr_flags[1] = 1'b1;
    tick("clr_alone");
    check("wrap_ch1_udf_sticky_clr", 32'(bus_w.udf_sticky[1]), 32'd0);
    idle();
    load[1] = 1'b1; load_value[W +: W] = 8'd2;
    tick("reload_ch1");
    idle();
    clr_flags[1] = 1'b1; decr[1] = 1'b1; step[SW +: SW] = 4'd4;
    tick("clr_race");
    check("wrap_ch1_udf_sticky_race", 32'(bus_w.udf_sticky[1]), 32'd1);

    // clken low ignores everything, including clr and load.
    idle();
    clken = 1'b0; incr = 4'b1111; step = 16'hFFFF; clr_flags = 4'b1111;
    load = 4'b0101; load_value = 32'h11223344;
    tick("clken_low_a");
    tick("clken_low_b");

    // Only ch2 increments.
    idle();
    incr[2] = 1'b1; step[2*SW +: SW] = 4'd9;
    tick("ch2_only");

    // Asynchronous reset mid-operation, between edges.
    idle();
    incr = 4'b1111; step = 16'h7777;
    tick("pre_reset");
    #3 rst = 1'b1;
    #1 model_reset();
    compare_all("async_reset");
    @(posedge clk); #1 compare_all("async_reset_edge");
    rst = 1'b0;

    // Randomized phase.
    for (int it = 0; it < 400; it++) begin
      clken = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < NCH; c++) begin
        load[c] = ($urandom_range(0, 9) == 0);
        incr[c] = $urandom_range(0, 1);
        decr[c] = $urandom_range(0, 1);
        clr_flags[c] = ($urandom_range(0, 5) == 0);
        step[c*SW +: SW] = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1)
          load_value[c*W +: W] = 8'($urandom_range(0, 15));
        else
          load_value[c*W +: W] = 8'($urandom_range(240, 255));
      end
      tick($sformatf("rand%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
